// File: rtl/z_decode_pkg.sv
// Shared encodings and decoded-control record for the decode stage.
// Optional feature macro: Z_DECODE_JAL_EN (adds jal decode).
package z_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
`ifdef Z_DECODE_JAL_EN
  localparam logic [5:0] OP_JAL   = 6'h03;
`endif
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_SLT = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_XOR = 4'd7,
    ALU_NOR = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic        jump;
    logic        branch;
    logic        branch_ne;
    logic        mem_to_reg;
    logic        sign_ext;
    logic        reg_dest;
    logic        mem_write;
    logic        alu_sel;
    logic        reg_write;
    logic        link;
    logic        illegal;
    alu_op_e     alu_op;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } dec_ctrl_t;

endpackage

// File: rtl/z_decode_stage_if.sv
// Fetch-side and execute-side handshake/bus of the decode stage.
interface z_decode_stage_if #(parameter int PC_W = 32);
  logic            in_valid, in_ready;
  logic [31:0]     in_insn;
  logic [PC_W-1:0] in_pc;
  logic            out_valid, out_ready;
  logic [PC_W-1:0] out_pc;
  logic            out_jump, out_branch, out_branch_ne, out_mem_to_reg, out_sign_ext;
  logic            out_reg_dest, out_mem_write, out_alu_sel, out_reg_write, out_link, out_illegal;
  logic [3:0]      out_alu_op;
  logic [4:0]      out_shamt, out_rs, out_rt, out_rd;
  logic [15:0]     out_imm;
  logic [25:0]     out_target;

  modport slave (
    input  in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_jump, out_branch, out_branch_ne,
           out_mem_to_reg, out_sign_ext, out_reg_dest, out_mem_write, out_alu_sel,
           out_reg_write, out_link, out_illegal, out_alu_op, out_shamt, out_rs,
           out_rt, out_rd, out_imm, out_target
  );
  modport master (
    output in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_jump, out_branch, out_branch_ne,
           out_mem_to_reg, out_sign_ext, out_reg_dest, out_mem_write, out_alu_sel,
           out_reg_write, out_link, out_illegal, out_alu_op, out_shamt, out_rs,
           out_rt, out_rd, out_imm, out_target
  );
endinterface

// File: rtl/z_decode_ctrl.sv
// Combinational instruction decoder: 32-bit word -> dec_ctrl_t.
// Optional feature macro: Z_DECODE_JAL_EN (jal recognised; else illegal).
module z_decode_ctrl
  import z_decode_pkg::*;
(
  input  logic [31:0] i_insn,
  output dec_ctrl_t   o_ctrl
);
  logic [5:0] w_op, w_fn;
  assign w_op = i_insn[31:26];
  assign w_fn = i_insn[5:0];

  // Opcode/funct decode; illegal encodings get every flag cleared afterwards
  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alu_op = ALU_ADD;
    o_ctrl.rs     = i_insn[25:21];
    o_ctrl.rt     = i_insn[20:16];
    o_ctrl.rd     = i_insn[15:11];
    o_ctrl.imm    = i_insn[15:0];
    o_ctrl.target = i_insn[25:0];
    case (w_op)
      OP_RTYPE: begin
        o_ctrl.reg_dest  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.shamt     = i_insn[10:6];
        case (w_fn)
          FN_ADDU: o_ctrl.alu_op = ALU_ADD;
          FN_SUBU: o_ctrl.alu_op = ALU_SUB;
          FN_AND:  o_ctrl.alu_op = ALU_AND;
          FN_OR:   o_ctrl.alu_op = ALU_OR;
          FN_SLT:  o_ctrl.alu_op = ALU_SLT;
          FN_SLL:  o_ctrl.alu_op = ALU_SLL;
          FN_SRL:  o_ctrl.alu_op = ALU_SRL;
          FN_XOR:  o_ctrl.alu_op = ALU_XOR;
          FN_NOR:  o_ctrl.alu_op = ALU_NOR;
          default: o_ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDIU: begin
        o_ctrl.alu_sel = 1'b1; o_ctrl.sign_ext = 1'b1; o_ctrl.reg_write = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl.alu_sel = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALU_AND;
      end
      OP_ORI: begin
        o_ctrl.alu_sel = 1'b1; o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALU_OR;
      end
      OP_BEQ, OP_BNE: begin
        o_ctrl.branch    = 1'b1;
        o_ctrl.sign_ext  = 1'b1;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.branch_ne = (w_op == OP_BNE);
      end
      OP_LW: begin
        o_ctrl.alu_sel = 1'b1; o_ctrl.sign_ext = 1'b1;
        o_ctrl.reg_write = 1'b1; o_ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alu_sel = 1'b1; o_ctrl.sign_ext = 1'b1; o_ctrl.mem_write = 1'b1;
      end
      OP_J: o_ctrl.jump = 1'b1;
`ifdef Z_DECODE_JAL_EN
      OP_JAL: begin
        o_ctrl.jump = 1'b1; o_ctrl.reg_write = 1'b1;
        o_ctrl.link = 1'b1; o_ctrl.rd = LINK_REG;
      end
`endif
      default: o_ctrl.illegal = 1'b1;
    endcase
    // Nothing downstream may act on an unsupported encoding; fields stay visible
    if (o_ctrl.illegal) begin
      o_ctrl.jump = 1'b0;      o_ctrl.branch = 1'b0;    o_ctrl.branch_ne = 1'b0;
      o_ctrl.mem_to_reg = 1'b0; o_ctrl.sign_ext = 1'b0; o_ctrl.reg_dest = 1'b0;
      o_ctrl.mem_write = 1'b0; o_ctrl.alu_sel = 1'b0;   o_ctrl.reg_write = 1'b0;
      o_ctrl.link = 1'b0;      o_ctrl.alu_op = ALU_ADD;
    end
  end
endmodule

// File: rtl/z_decode_stage.sv
// Registered decode stage with a 2-entry (output reg + skid) valid/ready buffer.
// in_ready comes straight from the skid-valid flop, so out_ready never reaches it.
// Optional feature macro: Z_DECODE_JAL_EN (jal decode and live out_link).
module z_decode_stage
  import z_decode_pkg::*;
#(
  parameter int PC_W          = 32,
  parameter int SKID_EN_DEPTH = 2
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  z_decode_stage_if.slave  bus
);
  if (SKID_EN_DEPTH != 2) begin : g_bad_depth
    $error("z_decode_stage: SKID_EN_DEPTH must be 2");
  end

  typedef struct packed {
    logic [PC_W-1:0] pc;
    dec_ctrl_t       ctrl;
  } ent_t;

  ent_t      r_out, r_skid, w_in;
  logic      r_out_vld, r_skid_vld;
  dec_ctrl_t w_ctrl;
  logic      w_acc, w_load;

  z_decode_ctrl u_ctrl (.i_insn(bus.in_insn), .o_ctrl(w_ctrl));

  assign w_in   = '{pc: bus.in_pc, ctrl: w_ctrl};
  assign w_acc  = bus.in_valid && !r_skid_vld;
  // Output register may take a new entry when empty or being consumed
  assign w_load = !r_out_vld || bus.out_ready;

  // Buffer update: flush wins; drained output prefers the skid entry over new input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_out      <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_load) begin
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;   // in_ready was 0, so no input this cycle
      end else begin
        r_out_vld <= w_acc;
        if (w_acc) r_out <= w_in;
      end
    end else if (w_acc) begin
      r_skid     <= w_in;
      r_skid_vld <= 1'b1;
    end
  end

  assign bus.in_ready       = !r_skid_vld;
  assign bus.out_valid      = r_out_vld;
  assign bus.out_pc         = r_out.pc;
  assign bus.out_jump       = r_out.ctrl.jump;
  assign bus.out_branch     = r_out.ctrl.branch;
  assign bus.out_branch_ne  = r_out.ctrl.branch_ne;
  assign bus.out_mem_to_reg = r_out.ctrl.mem_to_reg;
  assign bus.out_sign_ext   = r_out.ctrl.sign_ext;
  assign bus.out_reg_dest   = r_out.ctrl.reg_dest;
  assign bus.out_mem_write  = r_out.ctrl.mem_write;
  assign bus.out_alu_sel    = r_out.ctrl.alu_sel;
  assign bus.out_reg_write  = r_out.ctrl.reg_write;
  assign bus.out_illegal    = r_out.ctrl.illegal;
  assign bus.out_alu_op     = r_out.ctrl.alu_op;
  assign bus.out_shamt      = r_out.ctrl.shamt;
  assign bus.out_rs         = r_out.ctrl.rs;
  assign bus.out_rt         = r_out.ctrl.rt;
  assign bus.out_rd         = r_out.ctrl.rd;
  assign bus.out_imm        = r_out.ctrl.imm;
  assign bus.out_target     = r_out.ctrl.target;
`ifdef Z_DECODE_JAL_EN
  assign bus.out_link       = r_out.ctrl.link;
`else
  logic w_unused_link;
  assign w_unused_link      = r_out.ctrl.link;
  assign bus.out_link       = 1'b0;
`endif
endmodule

// File: tb/tb_z_decode_stage.sv
// Bench for z_decode_stage: queue-based model of a 2-deep registered buffer
// plus a table-style decoder, checked every cycle, and literal spot checks.
module tb_z_decode_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  z_decode_stage_if #(.PC_W(32)) bus ();
  z_decode_stage #(.PC_W(32), .SKID_EN_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  typedef struct packed {
    logic jump, branch, branch_ne, mem_to_reg, sign_ext, reg_dest;
    logic mem_write, alu_sel, reg_write, link, illegal;
    logic [3:0]  alu;
    logic [4:0]  shamt, rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] pc;
  } exp_t;

  localparam logic [127:0] ALL = '1;
  int n_pass = 0, n_tot = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e,
                     input logic [127:0] m);
    n_tot++;
    if (((a ^ e) & m) !== '0)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a & m, e & m, $time);
    else n_pass++;
  endtask

  // Spec-level decode of one instruction
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e = '0;
    e.rs = i[25:21]; e.rt = i[20:16]; e.rd = i[15:11];
    e.imm = i[15:0]; e.target = i[25:0]; e.pc = pc;
    case (i[31:26])
      6'h00: begin
        e.shamt = i[10:6]; e.reg_dest = 1; e.reg_write = 1;
        case (i[5:0])
          6'h21: e.alu = 0;  6'h23: e.alu = 1;  6'h24: e.alu = 2;
          6'h25: e.alu = 3;  6'h2a: e.alu = 4;  6'h00: e.alu = 5;
          6'h02: e.alu = 6;  6'h26: e.alu = 7;  6'h27: e.alu = 8;
          default: e.illegal = 1;
        endcase
      end
      6'h09: begin e.alu_sel = 1; e.sign_ext = 1; e.reg_write = 1; end
      6'h0c: begin e.alu_sel = 1; e.reg_write = 1; e.alu = 2; end
      6'h0d: begin e.alu_sel = 1; e.reg_write = 1; e.alu = 3; end
      6'h04: begin e.branch = 1; e.sign_ext = 1; e.alu = 1; end
      6'h05: begin e.branch = 1; e.sign_ext = 1; e.alu = 1; e.branch_ne = 1; end
      6'h23: begin e.alu_sel = 1; e.sign_ext = 1; e.reg_write = 1; e.mem_to_reg = 1; end
      6'h2b: begin e.alu_sel = 1; e.sign_ext = 1; e.mem_write = 1; end
      6'h02: e.jump = 1;
`ifdef Z_DECODE_JAL_EN
      6'h03: begin e.jump = 1; e.reg_write = 1; e.link = 1; e.rd = 5'd31; end
`endif
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin
      e.jump = 0; e.branch = 0; e.reg_write = 0; e.mem_write = 0; e.mem_to_reg = 0;
    end
    return e;
  endfunction

  // Flags the spec leaves open for illegal encodings are not compared
  function automatic logic [127:0] mask_of(input exp_t e);
    exp_t m = '1;
    if (e.illegal) begin
      m.sign_ext = 0; m.reg_dest = 0; m.alu_sel = 0; m.branch_ne = 0; m.link = 0; m.alu = '0;
    end
    return 128'(m);
  endfunction

  function automatic exp_t act();
    exp_t a;
    a.jump = bus.out_jump; a.branch = bus.out_branch; a.branch_ne = bus.out_branch_ne;
    a.mem_to_reg = bus.out_mem_to_reg; a.sign_ext = bus.out_sign_ext;
    a.reg_dest = bus.out_reg_dest; a.mem_write = bus.out_mem_write;
    a.alu_sel = bus.out_alu_sel; a.reg_write = bus.out_reg_write;
    a.link = bus.out_link; a.illegal = bus.out_illegal; a.alu = bus.out_alu_op;
    a.shamt = bus.out_shamt; a.rs = bus.out_rs; a.rt = bus.out_rt; a.rd = bus.out_rd;
    a.imm = bus.out_imm; a.target = bus.out_target; a.pc = bus.out_pc;
    return a;
  endfunction

  // Buffer model: FIFO of at most 2 decoded entries, head is what is presented
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) q.delete();
    else begin
      automatic bit acc  = bus.in_valid && (q.size() < 2);
      automatic bit cons = (q.size() > 0) && bus.out_ready;
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(model(bus.in_insn, bus.in_pc));
    end
  end

  // Compare DUT against model mid-cycle
  always @(negedge clk) if (rst_n) begin
    chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0), ALL);
    chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2), ALL);
    if (q.size() > 0) chk("outputs", 128'(act()), 128'(q[0]), mask_of(q[0]));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] insn, input logic [31:0] pc);
    int n = 0;
    logic rdy;
    bus.in_valid = 1; bus.in_insn = insn; bus.in_pc = pc;
    do begin rdy = bus.in_ready; step(); n++; end while (!rdy && n < 50);
    chk("accept_timeout", 128'(rdy), 128'(1), ALL);
    bus.in_valid = 0;
  endtask

  logic [31:0] tbl [8] = '{32'h14220003, 32'h3022ffff, 32'h3422ffff, 32'h00011082,
                           32'h00011080, 32'h00221826, 32'h00221827, 32'h0022182A};
  logic [15:0] pat = 16'b1011_0010_1110_0101;

  initial begin
    bus.in_valid = 0; bus.in_insn = '0; bus.in_pc = '0; bus.out_ready = 0;
    repeat (3) step();
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0), ALL);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1), ALL);
    chk("rst_outputs", 128'(act()), 128'(0), ALL);
    rst_n = 1; step();

    // addiu $2,$1,5
    bus.out_ready = 1;
    send(32'h24220005, 32'h100);
    chk("addiu_vld", 128'(bus.out_valid), 128'(1), ALL);
    chk("addiu_flags", 128'({bus.out_reg_write, bus.out_alu_sel, bus.out_sign_ext}), 128'(3'b111), ALL);
    chk("addiu_rt_imm", 128'({bus.out_rt, bus.out_imm}), 128'({5'd2, 16'h0005}), ALL);

    // back-to-back stream, one per cycle
    send(32'h00221821, 32'h104);
    chk("addu", 128'({bus.out_alu_op, bus.out_reg_dest, bus.out_rd}), 128'({4'd0, 1'b1, 5'd3}), ALL);
    send(32'h8C430004, 32'h108);
    chk("lw", 128'({bus.out_alu_op, bus.out_mem_to_reg, bus.out_reg_write}), 128'({4'd0, 2'b11}), ALL);
    send(32'hAC430004, 32'h10c);
    chk("sw", 128'({bus.out_mem_write, bus.out_reg_write}), 128'(2'b10), ALL);
    send(32'h10220003, 32'h110);
    chk("beq", 128'({bus.out_alu_op, bus.out_branch, bus.out_branch_ne}), 128'({4'd1, 2'b10}), ALL);
    step();

    // backpressure: 3 offered, out_ready low for 3 cycles
    bus.out_ready = 0;
    fork
      begin
        send(32'h00221821, 32'h200);
        send(32'h00221823, 32'h204);
        chk("full_in_ready", 128'(bus.in_ready), 128'(0), ALL);
        send(32'h00221824, 32'h208);
      end
      begin repeat (3) step(); bus.out_ready = 1; end
    join
    chk("stall_last_pc", 128'(bus.out_pc), 128'(32'h208), ALL);
    step();

    // illegal encodings
    send(32'h0022182B, 32'h300);
    chk("ill_funct", 128'({bus.out_illegal, bus.out_reg_write, bus.out_mem_write,
        bus.out_branch, bus.out_jump}), 128'(5'b10000), ALL);
    send(32'hFC000000, 32'h304);
    chk("ill_op", 128'({bus.out_illegal, bus.out_reg_write, bus.out_mem_write,
        bus.out_branch, bus.out_jump}), 128'(5'b10000), ALL);
    step();

    // flush with both entries full, together with out_ready
    bus.out_ready = 0;
    send(32'h24220001, 32'h400);
    send(32'h24220002, 32'h404);
    flush = 1; bus.out_ready = 1; bus.in_valid = 1; bus.in_insn = 32'h24220003;
    step();
    flush = 0; bus.in_valid = 0;
    chk("flush_vld", 128'(bus.out_valid), 128'(0), ALL);
    chk("flush_rdy", 128'(bus.in_ready), 128'(1), ALL);
    // flush drops an input offered in the same cycle
    bus.out_ready = 0;
    send(32'h24220004, 32'h408);
    flush = 1; bus.in_valid = 1; bus.in_insn = 32'h24220005; bus.in_pc = 32'h40c;
    step();
    flush = 0; bus.in_valid = 0;
    step();
    chk("flush_drop", 128'(bus.out_valid), 128'(0), ALL);

    // jal
    bus.out_ready = 1;
    send(32'h0C000010, 32'h500);
`ifdef Z_DECODE_JAL_EN
    chk("jal", 128'({bus.out_jump, bus.out_link, bus.out_reg_write, bus.out_rd, bus.out_target}),
        128'({3'b111, 5'd31, 26'h10}), ALL);
`else
    chk("jal_off", 128'({bus.out_illegal, bus.out_link, bus.out_jump}), 128'(3'b100), ALL);
`endif
    step();

    // mixed stream under a toggling out_ready
    fork
      for (int i = 0; i < 8; i++) send(tbl[i], 32'h600 + 32'(i) * 4);
      for (int k = 0; k < 24; k++) begin bus.out_ready = pat[k % 16]; step(); end
    join
    bus.out_ready = 1;
    repeat (3) step();

    // reset during a stall loses everything at once
    bus.out_ready = 0;
    send(32'h24220006, 32'h700);
    send(32'h24220007, 32'h704);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_vld", 128'(bus.out_valid), 128'(0), ALL);
    chk("rst_mid_rdy", 128'(bus.in_ready), 128'(1), ALL);
    chk("rst_mid_pc", 128'(bus.out_pc), 128'(0), ALL);
    step();
    rst_n = 1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/z_decode_stage.md
# z_decode_stage

Registered, flow-controlled instruction decode stage for the single-issue MIPS-subset core, sitting between fetch and register-read/execute. Each accepted 32-bit instruction and its PC is decoded into datapath control flags, ALU operation, register specifiers and immediate, then presented one cycle later. A 2-entry skid buffer gives full throughput under valid/ready backpressure, and a synchronous flush discards in-flight entries on branch/jump redirect. Unsupported encodings are flagged illegal, with every side-effecting control forced to 0.

## Interface
- `PC_W`, 32, width of `in_pc`/`out_pc`
- `SKID_EN_DEPTH`, 2, total entries (output register + skid); only 2 is legal
- `clk` input 1 — sole clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `flush` input 1 — synchronous discard of all held entries
- `in_valid` input 1 / `in_ready` output 1 — upstream handshake
- `in_insn` input 32 — instruction word
- `in_pc` input PC_W — instruction address
- `out_valid` output 1 / `out_ready` input 1 — downstream handshake
- `out_pc` output PC_W — PC of presented instruction
- `out_jump`, `out_branch`, `out_branch_ne`, `out_mem_to_reg`, `out_sign_ext`, `out_reg_dest`, `out_mem_write`, `out_alu_sel`, `out_reg_write`, `out_link`, `out_illegal` output 1 each
- `out_alu_op` output 4 — ALU operation (package encoding)
- `out_shamt` output 5 — `insn[10:6]` for R-type, else 0
- `out_rs`, `out_rt`, `out_rd` output 5 each — `insn[25:21]`, `[20:16]`, `[15:11]`; for jal, `out_rd`=31
- `out_imm` output 16 — `insn[15:0]`; `out_target` output 26 — `insn[25:0]`

## Operation
- ALU encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6, XOR=7, NOR=8.
- Opcode 000000 (R-type): reg_dest=1, reg_write=1. Funct mapping: 100001→ADD, 100011→SUB, 100100→AND, 100101→OR, 101010→SLT, 000000→SLL, 000010→SRL, 100110→XOR, 100111→NOR. Any other funct → illegal.
- 001001 addiu: alu_sel=1, sign_ext=1, reg_write=1, ADD.
- 001100 andi / 001101 ori: alu_sel=1, sign_ext=0, reg_write=1, AND / OR.
- 000100 beq / 000101 bne: branch=1, sign_ext=1, SUB; branch_ne=1 only for bne.
- 100011 lw: alu_sel=1, sign_ext=1, reg_write=1, mem_to_reg=1, ADD.
- 101011 sw: alu_sel=1, sign_ext=1, mem_write=1, ADD.
- 000010 j: jump=1.
- Every flag not listed above is 0, and alu_op defaults to ADD.
- Illegal instruction: illegal=1 and jump/branch/reg_write/mem_write/mem_to_reg=0. Field outputs are still driven.
- Buffer behaviour:
  - An entry is accepted when in_valid && in_ready.
  - The output register loads when it is empty or being consumed (out_valid && out_ready); otherwise the entry goes to the skid slot.
  - in_ready = !skid_full, taken directly from a register with no combinational path from out_ready.
  - When the output register drains, the skid entry moves into it before any new input.
- flush: on the next edge both entries are invalidated, and an input offered in the flush cycle is dropped. in_ready=1 on the following cycle.

## Timing
- Reset (async assert, sync-safe release): out_valid=0, in_ready=1, all control outputs 0, out_alu_op=ADD, all fields 0.
- Latency: accepted at edge N → out_valid at N+1 with outputs registered (no combinational in→out path).
- Throughput: 1/cycle when out_ready is held 1.
- Stall: outputs hold stable while out_valid && !out_ready.
- Full: both entries held → in_ready=0 the next cycle; an accept and a consume in the same cycle keep occupancy constant.
- Simultaneous flush and out_ready: flush wins; no entry is re-presented.
- Reset mid-stall: all entries are lost immediately.

## Configuration
- `Z_DECODE_JAL_EN` defined: opcode 000011 jal decodes to jump=1, reg_write=1, link=1, out_rd=31.
- Undefined: 000011 → illegal, and out_link is tied to 0.

## Structure
- Package `z_decode_pkg`: opcode/funct localparams, `alu_op_e` enum, `dec_ctrl_t` packed struct (all flags, alu_op, shamt, rs/rt/rd, imm, target).
- Sub-module `z_decode_ctrl`: purely combinational insn→`dec_ctrl_t`. `z_decode_stage` holds the two-entry buffer of `{pc, dec_ctrl_t}`.

## Test plan
- Reset, then in_insn=0x24220005 (addiu $2,$1,5), out_ready=1 → next cycle out_valid=1, reg_write=1, alu_sel=1, sign_ext=1, rt=2, imm=0x0005.
- Back-to-back stream of 0x00221821 (addu), 0x8C430004 (lw), 0xAC430004 (sw), 0x10220003 (beq) with out_ready=1 → four consecutive valid cycles with the correct flags/alu_op, in order.
- Hold out_ready=0 for 3 cycles while offering 3 instructions → in_ready drops after 2 accepts; release → both emerge in order, none lost or duplicated.
- 0x0022182B (funct 101011) and opcode 111111 → illegal=1, reg_write=mem_write=branch=jump=0.
- flush asserted with both entries full → out_valid=0 next cycle, in_ready=1, no stale output.
- 0x0C000010: with `Z_DECODE_JAL_EN` → jump=1, link=1, reg_write=1, rd=31, target=0x10; without it → illegal=1.
